// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit: op encodings
//   (as presented on the 2-bit op port), FSM state encoding, default width,
//   iteration count and the LO value returned on a divide by zero.
package mips_muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned ITER      = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/mips_muldiv_negate.sv
// mips_muldiv_negate
//   Combinational conditional two's-complement negate.
//   Ports:
//     din  [WIDTH-1:0]  value
//     neg               1 = output -din, 0 = output din
//     dout [WIDTH-1:0]  result
module mips_muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv
//   Iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO.
//   Operands are made unsigned at accept, 32 shift-add / restoring
//   shift-subtract iterations run in RUN, and FIX applies sign correction
//   and writes HI/LO in one step.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     start, op     request (accepted only when busy=0) and operation
//     a, b          rs / rt operands
//     busy          RUN or FIX in progress
//     done          one-cycle pulse, hi/lo hold the new result
//     hi, lo        result registers
//     div_by_zero   last completed divide had b==0
//   Build option: define MIPS_MULDIV_FAST_ZERO_EN to finish zero-operand
//   multiplies and zero-dividend divides one edge after accept.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    md_state_e state_q, state_d;
    md_op_e    op_in, op_q;

    logic             accept, is_mul_in, is_signed_in, div0_in, fast_zero, skip;
    logic             is_mul_q, prod_neg_q, rem_neg_q, div0_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] work_hi_q, work_lo_q, opnd_q;
    logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    assign op_in        = md_op_e'(op);
    assign is_mul_in    = (op_in == MD_MULT) || (op_in == MD_MULTU);
    assign is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign div0_in      = !is_mul_in && (b == '0);
    assign is_mul_q     = (op_q == MD_MULT) || (op_q == MD_MULTU);

`ifdef MIPS_MULDIV_FAST_ZERO_EN
    assign fast_zero = is_mul_in ? ((a == '0) || (b == '0)) : ((a == '0) && (b != '0));
`else
    assign fast_zero = 1'b0;
`endif
    // Early-exit ops bypass RUN; their final HI/LO are preloaded at accept.
    assign skip = div0_in || fast_zero;

    mips_muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .din(a), .neg(is_signed_in & a[WIDTH-1]), .dout(abs_a));
    mips_muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .din(b), .neg(is_signed_in & b[WIDTH-1]), .dout(abs_b));
    mips_muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .din({work_hi_q, work_lo_q}), .neg(prod_neg_q), .dout(prod_fix));
    mips_muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .din(work_lo_q), .neg(prod_neg_q), .dout(quo_fix));
    mips_muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .din(work_hi_q), .neg(rem_neg_q), .dout(rem_fix));

    // Multiply: {work_hi, work_lo} is the product/multiplier shift register.
    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: work_hi is the partial remainder, work_lo shifts dividend out
    // and quotient bits in. The remainder stays below the divisor, so the
    // subtraction result always fits in WIDTH bits.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done   = (state_q == ST_DONE);
                accept = start;
                if (start) state_d = skip ? ST_FIX : ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= MD_MULT;
            cnt_q       <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            opnd_q      <= '0;
            prod_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            div0_q      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q        <= op_in;
            cnt_q       <= '0;
            div0_q      <= div0_in;
            div_by_zero <= 1'b0;
            if (skip) begin
                work_hi_q  <= div0_in ? a : '0;
                work_lo_q  <= div0_in ? WIDTH'(DIV0_LO) : '0;
                prod_neg_q <= 1'b0;
                rem_neg_q  <= 1'b0;
            end else begin
                work_hi_q  <= '0;
                work_lo_q  <= is_mul_in ? abs_b : abs_a;
                opnd_q     <= is_mul_in ? abs_a : abs_b;
                prod_neg_q <= is_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                rem_neg_q  <= is_signed_in & a[WIDTH-1];
            end
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (is_mul_q) begin
                work_hi_q <= mul_sum[WIDTH:1];
                work_lo_q <= {mul_sum[0], work_lo_q[WIDTH-1:1]};
            end else begin
                work_hi_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                work_lo_q <= {work_lo_q[WIDTH-2:0], div_ge};
            end
        end else if (state_q == ST_FIX) begin
            hi          <= is_mul_q ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
            lo          <= is_mul_q ? prod_fix[WIDTH-1:0]       : quo_fix;
            div_by_zero <= div0_q;
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv
//   Self-checking bench for mips_muldiv. Expected HI/LO/flag/latency come
//   from native 64-bit arithmetic, pushed to a scoreboard at issue time and
//   popped when done is observed.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        e.dz  = 1'b0;
        e.lat = 33;
        if (o == 2'b00 || o == 2'b01) begin
            if (o == 2'b00) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'h0, x});
                sy = longint'({32'h0, y});
            end
            p = 64'(sx * sy);
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MIPS_MULDIV_FAST_ZERO_EN
            if (x == 0 || y == 0) e.lat = 1;
`endif
        end else if (y == 0) begin
            e.hi  = x;
            e.lo  = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            if (o == 2'b10) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'h0, x});
                sy = longint'({32'h0, y});
            end
            q = sx / sy;
            r = sx % sy;
            p = 64'(q);
            e.lo = p[31:0];
            p = 64'(r);
            e.hi = p[31:0];
`ifdef MIPS_MULDIV_FAST_ZERO_EN
            if (x == 0) e.lat = 1;
`endif
        end
        return e;
    endfunction

    // Issue one op (accepted at the next edge), push its expectation, then
    // wait (bounded) for done. lat counts edges after the accept edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise,
                          output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dz,
                          output int lat, output int busy_cyc, output logic dz_acc, output bit to);
        sb.push_back(model(o, x, y));
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
        dz_acc = div_by_zero;
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            if (noise && lat == 5) begin
                start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
            end else if (noise && lat == 8) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        to = !done;
        r_hi = hi; r_lo = lo; r_dz = div_by_zero;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
        logic [31:0] xs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] ys  [4] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFEDC_BA98};
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, rh, rl, rd, lat, bc, dza, to);
            e = sb.pop_front();
            checks++; if (rh !== e.hi) begin errors++; $display("FAIL mult%0d_hi: got %h want %h", i, rh, e.hi); end
            checks++; if (rl !== e.lo) begin errors++; $display("FAIL mult%0d_lo: got %h want %h", i, rl, e.lo); end
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL mult%0d_latency: got %0d want %0d", i, lat, e.lat); end
            checks++; if (bc != e.lat) begin errors++; $display("FAIL mult%0d_busy_cycles: got %0d want %0d", i, bc, e.lat); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult%0d_done_pulse: got done=%b busy=%b want 0 0", i, done, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, rd, lat, bc, dza, to);
        e = sb.pop_front();
        checks++; if (rh !== e.hi || rl !== e.lo || to) begin errors++; $display("FAIL b2b_multu: got %h_%h want %h_%h", rh, rl, e.hi, e.lo); end
        // done is high now: this start lands in the DONE cycle.
        run_op(2'b11, 32'd100, 32'd7, 1'b0, rh, rl, rd, lat, bc, dza, to);
        e = sb.pop_front();
        checks++; if (rh !== e.hi) begin errors++; $display("FAIL b2b_divu_hi: got %h want %h", rh, e.hi); end
        checks++; if (rl !== e.lo) begin errors++; $display("FAIL b2b_divu_lo: got %h want %h", rl, e.lo); end
        checks++; if (to || lat != e.lat) begin errors++; $display("FAIL b2b_divu_latency: got %0d want %0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [1:0]  ops [6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [31:0] xs  [6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0007, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0003};
        logic [31:0] ys  [6] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_1234, 32'hFFFF_F00D, 32'hFFFF_FFFF};
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, rh, rl, rd, lat, bc, dza, to);
            e = sb.pop_front();
            checks++; if (rh !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, rh, e.hi); end
            checks++; if (rl !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, rl, e.lo); end
            checks++; if (rd !== e.dz) begin errors++; $display("FAIL div%0d_dz: got %b want %b", i, rd, e.dz); end
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, e.lat); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        logic [1:0]  ops [3] = '{2'b10, 2'b11, 2'b11};
        logic [31:0] xs  [3] = '{32'h0000_0005, 32'hFFFF_1234, 32'h0000_0009};
        logic [31:0] ys  [3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0003};
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, rh, rl, rd, lat, bc, dza, to);
            e = sb.pop_front();
            checks++; if (rh !== e.hi) begin errors++; $display("FAIL dz%0d_hi: got %h want %h", i, rh, e.hi); end
            checks++; if (rl !== e.lo) begin errors++; $display("FAIL dz%0d_lo: got %h want %h", i, rl, e.lo); end
            checks++; if (rd !== e.dz) begin errors++; $display("FAIL dz%0d_flag: got %b want %b", i, rd, e.dz); end
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL dz%0d_latency: got %0d want %0d", i, lat, e.lat); end
            if (i == 2) begin
                checks++; if (dza !== 1'b0) begin errors++; $display("FAIL dz_clear_on_accept: got %b want 0", dza); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        logic [1:0]  ops [2] = '{2'b00, 2'b10};
        logic [31:0] xs  [2] = '{32'h0001_E240, 32'hF000_0001};
        logic [31:0] ys  [2] = '{32'hFFFF_FFB3, 32'h0000_0013};
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b1, rh, rl, rd, lat, bc, dza, to);
            e = sb.pop_front();
            checks++; if (rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL ignore%0d_result: got %h_%h want %h_%h", i, rh, rl, e.hi, e.lo); end
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL ignore%0d_latency: got %0d want %0d", i, lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        start = 1'b1; op = 2'b01; a = 32'hCAFE_F00D; b = 32'h0BAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, rh, rl, rd, lat, bc, dza, to);
        e = sb.pop_front();
        checks++; if (rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL postreset_result: got %h_%h want %h_%h", rh, rl, e.hi, e.lo); end
        checks++; if (to || lat != e.lat) begin errors++; $display("FAIL postreset_latency: got %0d want %0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [31:0] xs  [4] = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        logic [31:0] ys  [4] = '{32'h0000_04D2, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF};
        logic [31:0] rh, rl; logic rd, dza; int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, rh, rl, rd, lat, bc, dza, to);
            e = sb.pop_front();
            checks++; if (rh !== e.hi || rl !== e.lo) begin errors++; $display("FAIL zero%0d_result: got %h_%h want %h_%h", i, rh, rl, e.hi, e.lo); end
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL zero%0d_latency: got %0d want %0d", i, lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid();
        test_zero();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit beside the single-cycle ALU; executes MULT, MULTU, DIV, DIVU and holds results in HI/LO.
- The ALU performs add/sub/logic/slt in one cycle; this block performs the inverse-heavy arithmetic (multiply and its inverse, divide) over multiple cycles.
- The core issues `start` with operands and stalls on `busy`. MFHI/MFLO read the `hi`/`lo` outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width (design verified at 32 only)
- CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  input  WIDTH  rs operand (dividend/multiplicand)
- b  input  WIDTH  rt operand (divisor/multiplier)
- busy  output  1  operation in progress; core must stall MFHI/MFLO/new mul-div
- done  output  1  one-cycle pulse; hi/lo hold new result this cycle
- hi  output  WIDTH  MULT upper product / DIV remainder
- lo  output  WIDTH  MULT lower product / DIV quotient
- div_by_zero  output  1  set with done when a DIV/DIVU had b==0; cleared on next accepted start

Behaviour:
- Reset (async assert, sync-release usage): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset mid-operation aborts; HI/LO return to 0.
- FSM states: IDLE, RUN, FIX, DONE. DONE is idle-equivalent: a start in DONE is accepted.
- Accept edge E0 (start=1, busy=0):
  - Latch op, |a|, |b| for signed ops, else raw values.
  - Latch sign flags: product sign = a[31]^b[31]; remainder sign = a[31].
  - Next state RUN, counter=0.
- RUN: one iteration per edge for edges E1..E32.
  - Multiply: shift-add, 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient/remainder registers.
  - After 32 iterations, go to FIX.
- FIX: one edge (E33).
  - Apply sign correction by two's-complement negate where the flag is set.
  - Write hi/lo and go to DONE.
  - Normal latency: done visible after E33. busy=1 in RUN and FIX, 0 in IDLE/DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN if start=1.
- Divide by zero (op DIV/DIVU, b==0): detected at accept; skip RUN and go to FIX.
  - Result: hi=a, lo=32'hFFFF_FFFF, div_by_zero=1.
  - done visible after E1.
- Signed overflow -2^31 / -1: natural result, lo=32'h8000_0000, hi=0. No flag.
- start while busy=1: ignored with no side effects. op/a/b changes during RUN: ignored.
- HI/LO hold their previous values until FIX writes them; never partially updated.
- Signed rules: quotient truncates toward zero; remainder takes the dividend's sign.

Optional Feature:
- Macro MIPS_MULDIV_FAST_ZERO_EN.
- Defined:
  - Multiply with a==0 or b==0 skips RUN: hi=0, lo=0, done after E1.
  - Divide with a==0 and b!=0 skips RUN: hi=0, lo=0, done after E1.
- Undefined: these cases take the full 33-cycle path, with identical results.
- Divide-by-zero early exit is present in both builds.

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - FSM state enum
  - WIDTH_DEF = 32
  - ITER = 32
  - DIV0_LO = 32'hFFFF_FFFF
- Sub-module mips_muldiv_negate: combinational conditional two's-complement, WIDTH-parameterised. Used for operand abs at accept and result fix in FIX.

Test Plan:
- MULT a=-3 (FFFFFFFD), b=7 -> hi=FFFFFFFF, lo=FFFFFFEB; done after 33rd edge; busy high 33 cycles.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Back-to-back: start in DONE cycle with DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
- DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
- DIV a=5, b=0 -> done after 1 edge, hi=5, lo=FFFFFFFF, div_by_zero=1. Next accepted start clears div_by_zero.
- Protocol and reset:
  - Mid-RUN, toggle start with new operands -> ignored; result matches the original op.
  - Assert rst_n=0 at iteration 10 -> busy/done/hi/lo immediately 0; a new op after release completes correctly.
- MULT a=0, b=1234 -> hi=lo=0. With MIPS_MULDIV_FAST_ZERO_EN done after 1 edge; without it, after 33 edges.
